key_decoder: RTL and testbench



---
 rtl/kbd_pkg.sv | 30 +++
 rtl/key_decoder_if.sv | 20 ++
 rtl/kbd_prefix_timer.sv | 27 ++
 rtl/key_decoder.sv | 124 ++++++++++++
 tb/tb_key_decoder.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// Shared PS/2 scancode constants and decoder state encoding.
package kbd_pkg;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_SPACE   = 8'h29;
  localparam logic [7:0] SC_LEFT    = 8'h6B;
  localparam logic [7:0] SC_RIGHT   = 8'h74;
  localparam logic [7:0] SC_A       = 8'h1C;
  localparam logic [7:0] SC_D       = 8'h23;
  localparam logic [7:0] SC_W       = 8'h1D;
  localparam logic [7:0] SC_BAT_OK  = 8'hAA;
  localparam logic [7:0] SC_BAT_ERR = 8'hFC;
  localparam logic [7:0] SC_OVR_LO  = 8'h00;
  localparam logic [7:0] SC_OVR_HI  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EXT       = 3'd1,
    ST_BREAK     = 3'd2,
    ST_EXT_BREAK = 3'd3
  } kbd_state_t;

  // Keyboard self-test and overrun codes force a resync from any state.
  function automatic logic is_resync(input logic [7:0] b);
    return (b == SC_BAT_OK) || (b == SC_BAT_ERR) ||
           (b == SC_OVR_LO) || (b == SC_OVR_HI);
  endfunction

endpackage

// File: rtl/key_decoder_if.sv
// Byte stream in, held-key levels out, between PS/2 receiver and
// character controller.
interface key_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       key_space;
  logic       key_left;
  logic       key_right;
  logic       seq_error;

  modport master (
    output rx_data, rx_valid,
    input  key_space, key_left, key_right, seq_error
  );

  modport slave (
    input  rx_data, rx_valid,
    output key_space, key_left, key_right, seq_error
  );
endinterface

// File: rtl/kbd_prefix_timer.sv
// Saturating counter bounding the gap after an E0/F0 prefix byte.
module kbd_prefix_timer #(
  parameter int unsigned LIMIT = 130_000,
  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !run) begin
      cnt <= '0;
    end else if (!tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_decoder.sv
// PS/2 scancode to held-key decoder; KEY_DECODER_WASD_EN adds W/A/D
// as alternates for space/left/right.
module key_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 130_000
) (
  input logic          clk,
  input logic          rst,
  key_decoder_if.slave bus
);

  kbd_state_t state;
  logic       sp_q, lf_q, rt_q;
  logic       err_q;
  logic       tc;
  logic       timeout;

  kbd_prefix_timer #(
    .LIMIT (PREFIX_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (state != ST_IDLE),
    .clear (bus.rx_valid),
    .tc    (tc)
  );

  assign timeout = tc && (state != ST_IDLE) && !bus.rx_valid;

`ifdef KEY_DECODER_WASD_EN
  logic sp_a, lf_a, rt_a;
  assign bus.key_space = sp_q | sp_a;
  assign bus.key_left  = lf_q | lf_a;
  assign bus.key_right = rt_q | rt_a;
`else
  assign bus.key_space = sp_q;
  assign bus.key_left  = lf_q;
  assign bus.key_right = rt_q;
`endif
  assign bus.seq_error = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sp_q  <= 1'b0;
      lf_q  <= 1'b0;
      rt_q  <= 1'b0;
      err_q <= 1'b0;
`ifdef KEY_DECODER_WASD_EN
      sp_a  <= 1'b0;
      lf_a  <= 1'b0;
      rt_a  <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      if (bus.rx_valid) begin
        if (is_resync(bus.rx_data)) begin
          state <= ST_IDLE;
          sp_q  <= 1'b0;
          lf_q  <= 1'b0;
          rt_q  <= 1'b0;
          err_q <= (bus.rx_data != SC_BAT_OK);
`ifdef KEY_DECODER_WASD_EN
          sp_a  <= 1'b0;
          lf_a  <= 1'b0;
          rt_a  <= 1'b0;
`endif
        end else begin
          unique case (state)
            ST_IDLE: begin
              case (bus.rx_data)
                SC_EXT:   state <= ST_EXT;
                SC_BREAK: state <= ST_BREAK;
                SC_SPACE: sp_q  <= 1'b1;
`ifdef KEY_DECODER_WASD_EN
                SC_W:     sp_a  <= 1'b1;
                SC_A:     lf_a  <= 1'b1;
                SC_D:     rt_a  <= 1'b1;
`endif
                default:  state <= ST_IDLE;
              endcase
            end
            ST_EXT: begin
              state <= ST_IDLE;
              case (bus.rx_data)
                SC_BREAK: state <= ST_EXT_BREAK;
                SC_LEFT:  lf_q  <= 1'b1;
                SC_RIGHT: rt_q  <= 1'b1;
                default:  state <= ST_IDLE;
              endcase
            end
            ST_BREAK: begin
              state <= ST_IDLE;
              case (bus.rx_data)
                SC_SPACE: sp_q <= 1'b0;
`ifdef KEY_DECODER_WASD_EN
                SC_W:     sp_a <= 1'b0;
                SC_A:     lf_a <= 1'b0;
                SC_D:     rt_a <= 1'b0;
`endif
                default:  state <= ST_IDLE;
              endcase
            end
            ST_EXT_BREAK: begin
              state <= ST_IDLE;
              case (bus.rx_data)
                SC_LEFT:  lf_q  <= 1'b0;
                SC_RIGHT: rt_q  <= 1'b0;
                default:  state <= ST_IDLE;
              endcase
            end
            default: state <= ST_IDLE;
          endcase
        end
      end else if (timeout) begin
        // Stalled prefix: drop it, keep the held levels.
        state <= ST_IDLE;
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_decoder.sv
// Directed-vector bench for key_decoder (short prefix timeout).
module tb_key_decoder;

  localparam int unsigned LIM = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  key_decoder_if bus ();

  key_decoder #(
    .PREFIX_TIMEOUT (LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one strobe from a falling edge; returns at the next one.
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  function automatic logic [7:0] keys();
    return {4'h0, bus.seq_error, bus.key_space,
            bus.key_left, bus.key_right};
  endfunction

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", keys(), 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", keys(), 8'h00);

    // make / break space
    send(8'h29);
    chk("space_make", keys(), 8'h04);
    send(8'h29);
    chk("space_repeat", keys(), 8'h04);
    send(8'hF0);
    chk("space_break_pfx", keys(), 8'h04);
    send(8'h29);
    chk("space_break", keys(), 8'h00);

    // extended left / right
    send(8'hE0);
    send(8'h6B);
    chk("left_make", keys(), 8'h02);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("left_break", keys(), 8'h00);
    send(8'hE0);
    send(8'h74);
    chk("right_make", keys(), 8'h01);
    send(8'hE0);
    send(8'h6B);
    chk("left_right_both", keys(), 8'h03);
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("both_released", keys(), 8'h00);

    // prefix timeout
    send(8'hE0);
    repeat (LIM - 1) @(negedge clk);
    chk("timeout_not_yet", keys(), 8'h00);
    @(negedge clk);
    chk("timeout_pulse", keys(), 8'h08);
    @(negedge clk);
    chk("timeout_one_cycle", keys(), 8'h00);
    send(8'h6B);
    chk("after_timeout_6b", keys(), 8'h00);

    // timeout keeps held levels
    send(8'h29);
    send(8'hF0);
    repeat (LIM) @(negedge clk);
    chk("timeout_keeps_space", keys(), 8'h0C);
    send(8'h29);
    chk("space_still_held", keys(), 8'h04);
    send(8'hF0);
    send(8'h29);

    // byte lands on terminal count
    send(8'hE0);
    repeat (LIM - 1) @(negedge clk);
    send(8'h74);
    chk("byte_at_limit", keys(), 8'h01);
    @(negedge clk);
    chk("byte_at_limit_noerr", keys(), 8'h01);

    // resync codes
    send(8'h29);
    chk("space_and_right", keys(), 8'h05);
    send(8'hAA);
    chk("bat_ok_clears", keys(), 8'h00);
    send(8'h29);
    send(8'hFC);
    chk("bat_err_pulse", keys(), 8'h08);
    @(negedge clk);
    chk("bat_err_one_cycle", keys(), 8'h00);
    send(8'hE0);
    send(8'h00);
    chk("overrun_in_ext", keys(), 8'h08);
    send(8'h6B);
    chk("overrun_resets_fsm", keys(), 8'h00);
    send(8'hFF);
    chk("overrun_ff", keys(), 8'h08);

    // async reset mid-sequence
    send(8'h29);
    send(8'hF0);
    #2 rst = 1'b1;
    #1 chk("async_reset", keys(), 8'h00);
    #1 rst = 1'b0;
    @(negedge clk);
    send(8'h29);
    chk("post_reset_idle", keys(), 8'h04);
    send(8'hF0);
    send(8'h29);

    // alternate keys
    send(8'h1C);
`ifdef KEY_DECODER_WASD_EN
    chk("wasd_a_left", keys(), 8'h02);
    send(8'hE0);
    send(8'h6B);
    send(8'hF0);
    send(8'h1C);
    chk("wasd_primary_holds", keys(), 8'h02);
    send(8'h23);
    send(8'h1D);
    chk("wasd_d_w", keys(), 8'h07);
    send(8'hFC);
    chk("wasd_err_clears", keys(), 8'h08);
`else
    chk("a_ignored", keys(), 8'h00);
    send(8'h23);
    send(8'h1D);
    chk("d_w_ignored", keys(), 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
